// File: rtl/w_io_bank_if.sv
// w_io_bank_if: pad-side and fabric-side channel signals of the west-edge IO bank.
// The bank itself connects through the slave modport; whatever drives the pads
// and the fabric (switch matrix, or a testbench) uses the master modport.
interface w_io_bank_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]   pad_O;     // pad-to-core data
    logic [NUM_CH-1:0]   pad_I;     // core-to-pad data
    logic [NUM_CH-1:0]   pad_T;     // pad tristate, 1 = high-Z
    logic [NUM_CH-1:0]   fab_I;     // fabric output data
    logic [NUM_CH-1:0]   fab_T;     // fabric tristate request
    logic [NUM_CH-1:0]   fab_O;     // combinational pad data to fabric
    logic [NUM_CH-1:0]   fab_Q;     // synchronised pad data
    logic [NUM_CH-1:0]   fab_edge;  // one-cycle pulse on any fab_Q change
    logic [4*NUM_CH-1:0] cfg_C;     // user config-access bits, channel k at [4k+:4]
    logic                cfg_busy;  // a shadow load is waiting to commit

    modport master (
        output pad_O, fab_I, fab_T,
        input  pad_I, pad_T, fab_O, fab_Q, fab_edge, cfg_C, cfg_busy
    );

    modport slave (
        input  pad_O, fab_I, fab_T,
        output pad_I, pad_T, fab_O, fab_Q, fab_edge, cfg_C, cfg_busy
    );
endinterface

// File: rtl/w_io_bank.sv
// w_io_bank: parametrised west-edge IO bank with NUM_CH bidirectional pad channels.
// Each channel owns one configuration byte taken from the frame chain
// (frame CFG_FRAME + k/4, byte lane k%4):
//   [0] SYNC2   fab_Q through two flops instead of one
//   [1] OUT_REG register the pad_I path
//   [2] T_REG   register the pad_T path
//   [3] O_INV   invert the pad_I path
//   [4] T_INV   invert the pad_T path
//   [7:4]       also exported as the user cfg_C nibble; [7:5] otherwise unused
// Frame writes land in a shadow byte and are copied to the active byte on the
// first clock after the strobe drops, so a live pad never sees a partial config.
// Optional macro W_IO_BANK_FRAME_PIPE_EN registers FrameData_O / FrameStrobe_O,
// adding one cycle of chain latency; without it the chain is a straight feed-through.
module w_io_bank #(
    parameter int NUM_CH     = 2,
    parameter int FRAME_BITS = 32,
    parameter int MAX_FRAMES = 20,
    parameter int CFG_FRAME  = 0
) (
    input  logic                  UserCLK,
    input  logic                  RST,
    input  logic [FRAME_BITS-1:0] FrameData,
    input  logic [MAX_FRAMES-1:0] FrameStrobe,
    output logic [FRAME_BITS-1:0] FrameData_O,
    output logic [MAX_FRAMES-1:0] FrameStrobe_O,
    output logic                  UserCLKo,
    w_io_bank_if.slave            io
);

    localparam int LANES = (NUM_CH < 4) ? NUM_CH : 4;

    // Parameter sanity: bad combinations stop elaboration rather than
    // silently mapping channels onto frames or bits that do not exist.
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("w_io_bank: NUM_CH must be in 1..16");
    end
    if (NUM_CH > 4 * (MAX_FRAMES - CFG_FRAME)) begin : g_bad_frame_map
        $error("w_io_bank: NUM_CH exceeds the frames available after CFG_FRAME");
    end
    if (FRAME_BITS < 8 * LANES) begin : g_bad_frame_bits
        $error("w_io_bank: FRAME_BITS too narrow for the channel byte lanes");
    end

    logic [NUM_CH-1:0] pending_v;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int FRM  = CFG_FRAME + k / 4;
        localparam int LANE = (k % 4) * 8;

        logic [7:0] shadow;
        logic [7:0] active;
        logic       pending;
        logic       strobe;
        logic       commit;

        logic       sync1;    // first input flop
        logic       sync2;    // second input flop, used when SYNC2 is set
        logic       edge_q;   // registered edge pulse
        logic       settle;   // marks the cycle right after a commit
        logic       out_q;    // registered pad_I data
        logic       t_q;      // registered pad_T enable

        logic       d;
        logic       t;
        logic       pad_i;
        logic       pad_t;
        logic       fab_q;
        logic       next_q;
        logic       cur_q;

        assign strobe = FrameStrobe[FRM];
        assign commit = pending & ~strobe;

        // Shadow load while the strobe is high; single commit into active after it drops
        always_ff @(posedge UserCLK or posedge RST) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (RST) begin
                shadow  <= '0;
                active  <= '0;
                pending <= 1'b0;
            end else if (strobe) begin
                shadow  <= FrameData[LANE +: 8];
                pending <= 1'b1;
            end else if (pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
        end

        // Channel pipeline: cleared on commit so the new mode starts from a known state
        always_ff @(posedge UserCLK or posedge RST) begin
            if (RST) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                edge_q <= 1'b0;
                settle <= 1'b0;
                out_q  <= 1'b0;
                t_q    <= 1'b1;
            end else if (commit) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                edge_q <= 1'b0;
                settle <= 1'b1;
                out_q  <= 1'b0;
                t_q    <= 1'b1;
            end else begin
                sync1  <= io.pad_O[k];
                sync2  <= sync1;
                // The clear-to-zero after commit would look like an edge; mask it.
                edge_q <= settle ? 1'b0 : (next_q ^ cur_q);
                settle <= 1'b0;
                out_q  <= d;
                t_q    <= t;
            end
        end

        // Path selection for pad_I, pad_T and fab_Q from the active mode bits
        always_comb begin
            // NOTE: every output of a combinational block gets a default first so no latch is inferred.
            d      = io.fab_I[k] ^ active[3];
            t      = io.fab_T[k] ^ active[4];
            pad_i  = d;
            pad_t  = t;
            fab_q  = sync1;
            next_q = io.pad_O[k];
            cur_q  = sync1;
            if (active[1]) begin
                pad_i = out_q;
            end
            if (active[2]) begin
                pad_t = t_q;
            end
            if (active[0]) begin
                // edge_q looks one stage ahead so its pulse lines up with the fab_Q change
                fab_q  = sync2;
                next_q = sync1;
                cur_q  = sync2;
            end
        end

        assign io.pad_I[k]          = pad_i;
        assign io.pad_T[k]          = pad_t;
        assign io.fab_O[k]          = io.pad_O[k];
        assign io.fab_Q[k]          = fab_q;
        assign io.fab_edge[k]       = edge_q;
        assign io.cfg_C[4*k +: 4]   = active[7:4];
        assign pending_v[k]         = pending;
    end

    assign io.cfg_busy = |pending_v;

`ifdef W_IO_BANK_FRAME_PIPE_EN
    // One register stage on the configuration chain towards the next tile
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            FrameData_O   <= '0;
            FrameStrobe_O <= '0;
        end else begin
            FrameData_O   <= FrameData;
            FrameStrobe_O <= FrameStrobe;
        end
    end
`else
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;
`endif

    // Clock forwarded ungated; a technology clock-buffer cell replaces this at implementation.
    assign UserCLKo = UserCLK;

endmodule

// File: tb/tb_w_io_bank.sv
// tb_w_io_bank: directed checks from the bring-up plan followed by randomized
// traffic, all compared every cycle against a frame/channel-level model.
module tb_w_io_bank;

    localparam int NCH = 2;
    localparam int FB  = 32;
    localparam int MF  = 20;
    localparam int CF  = 0;

    logic          UserCLK = 1'b0;
    logic          RST = 1'b1;
    logic [FB-1:0] FrameData = '0;
    logic [MF-1:0] FrameStrobe = '0;
    logic [FB-1:0] FrameData_O;
    logic [MF-1:0] FrameStrobe_O;
    logic          UserCLKo;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    w_io_bank_if #(.NUM_CH(NCH)) bus ();

    w_io_bank #(
        .NUM_CH    (NCH),
        .FRAME_BITS(FB),
        .MAX_FRAMES(MF),
        .CFG_FRAME (CF)
    ) dut (
        .UserCLK      (UserCLK),
        .RST          (RST),
        .FrameData    (FrameData),
        .FrameStrobe  (FrameStrobe),
        .FrameData_O  (FrameData_O),
        .FrameStrobe_O(FrameStrobe_O),
        .UserCLKo     (UserCLKo),
        .io           (bus)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]    m_shadow  [NCH];
    logic [7:0]    m_active  [NCH];
    logic          m_pending [NCH];
    logic [1:0]    m_hist    [NCH];   // pad_O samples since last clear, [0] newest
    logic          m_outq    [NCH];
    logic          m_tq      [NCH];
    logic          m_edge    [NCH];
    int            m_since   [NCH];   // edges since the last commit, saturating at 2
    logic [FB-1:0] m_fd_q;
    logic [MF-1:0] m_fs_q;

    function automatic logic fabq(input int k);
        return m_active[k][0] ? m_hist[k][1] : m_hist[k][0];
    endfunction

    always @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NCH; k++) begin
                m_shadow[k]  = '0;
                m_active[k]  = '0;
                m_pending[k] = 1'b0;
                m_hist[k]    = '0;
                m_outq[k]    = 1'b0;
                m_tq[k]      = 1'b1;
                m_edge[k]    = 1'b0;
                m_since[k]   = 2;
            end
            m_fd_q = '0;
            m_fs_q = '0;
        end else begin
            m_fd_q = FrameData;
            m_fs_q = FrameStrobe;
            for (int k = 0; k < NCH; k++) begin
                logic strobe;
                logic old_q;
                strobe = FrameStrobe[CF + k/4];
                old_q  = fabq(k);
                if (!strobe && m_pending[k]) begin
                    m_active[k]  = m_shadow[k];
                    m_pending[k] = 1'b0;
                    m_hist[k]    = '0;
                    m_outq[k]    = 1'b0;
                    m_tq[k]      = 1'b1;
                    m_edge[k]    = 1'b0;
                    m_since[k]   = 0;
                end else begin
                    if (strobe) begin
                        m_shadow[k]  = FrameData[(k%4)*8 +: 8];
                        m_pending[k] = 1'b1;
                    end
                    m_outq[k] = bus.fab_I[k] ^ m_active[k][3];
                    m_tq[k]   = bus.fab_T[k] ^ m_active[k][4];
                    m_hist[k] = {m_hist[k][0], bus.pad_O[k]};
                    if (m_since[k] < 2) m_since[k]++;
                    m_edge[k] = (m_since[k] >= 2) && (fabq(k) != old_q);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [NCH-1:0]   e_fq, e_fe, e_pi, e_pt;
        logic [4*NCH-1:0] e_cc;
        logic             e_busy;
        forever begin
            @(negedge UserCLK);
            #2;
            if (cmp_en) begin
                e_busy = 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    e_fq[k] = fabq(k);
                    e_fe[k] = m_edge[k];
                    e_pi[k] = m_active[k][1] ? m_outq[k] : (bus.fab_I[k] ^ m_active[k][3]);
                    e_pt[k] = m_active[k][2] ? m_tq[k]   : (bus.fab_T[k] ^ m_active[k][4]);
                    e_cc[4*k +: 4] = m_active[k][7:4];
                    e_busy = e_busy | m_pending[k];
                end
                check("fab_O",    bus.fab_O,    bus.pad_O);
                check("fab_Q",    bus.fab_Q,    e_fq);
                check("fab_edge", bus.fab_edge, e_fe);
                check("pad_I",    bus.pad_I,    e_pi);
                check("pad_T",    bus.pad_T,    e_pt);
                check("cfg_C",    bus.cfg_C,    e_cc);
                check("cfg_busy", bus.cfg_busy, e_busy);
                check("UserCLKo", UserCLKo,     UserCLK);
`ifdef W_IO_BANK_FRAME_PIPE_EN
                check("FrameData_O",   FrameData_O,   m_fd_q);
                check("FrameStrobe_O", FrameStrobe_O, m_fs_q);
`else
                check("FrameData_O",   FrameData_O,   FrameData);
                check("FrameStrobe_O", FrameStrobe_O, FrameStrobe);
`endif
            end
        end
    end

    // Inputs change 1 time unit after the falling edge.
    task automatic tick();
        @(negedge UserCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        hold = 0;
        bus.pad_O = '0;
        bus.fab_I = 2'b11;
        bus.fab_T = 2'b00;
        repeat (3) tick();

        // Reset release: all paths combinational, nothing pending
        RST = 1'b0;
        cmp_en = 1'b1;
        #2;
        check("rst_pad_T",    bus.pad_T,    2'b00);
        check("rst_pad_I",    bus.pad_I,    2'b11);
        check("rst_fab_Q",    bus.fab_Q,    2'b00);
        check("rst_cfg_busy", bus.cfg_busy, 1'b0);
        check("rst_cfg_C",    bus.cfg_C,    8'h00);

        // Frame load 0x0000_A207 held for three cycles
        tick();
        FrameData   = 32'h0000_A207;
        FrameStrobe = 20'h00001;
        #2;
`ifdef W_IO_BANK_FRAME_PIPE_EN
        check("pipe_strobe_n", FrameStrobe_O, 20'h00000);
`else
        check("pipe_strobe_n", FrameStrobe_O, 20'h00001);
`endif
        tick(); #2;
        check("load_busy_1", bus.cfg_busy, 1'b1);
        check("pipe_strobe_n1", FrameStrobe_O, 20'h00001);
        tick(); #2;
        check("load_busy_2", bus.cfg_busy, 1'b1);
        tick();
        FrameStrobe = '0;
        #2;
        check("load_busy_after", bus.cfg_busy, 1'b1);
        tick(); #2;
        check("load_busy_done", bus.cfg_busy, 1'b0);
        check("load_cfg_C",     bus.cfg_C,    8'hA0);
        check("model_act0",     m_active[0],  8'h07);
        check("model_act1",     m_active[1],  8'hA2);

        // Channel 0 SYNC2: pad_O rises at n -> fab_Q and edge pulse at n+2
        tick(); tick();
        tick();
        bus.pad_O = 2'b01;
        #2;
        check("sync_n_fab_O",  bus.fab_O[0],    1'b1);
        check("sync_n_fab_Q",  bus.fab_Q[0],    1'b0);
        tick(); #2;
        check("sync_n1_fab_Q", bus.fab_Q[0],    1'b0);
        check("sync_n1_edge",  bus.fab_edge[0], 1'b0);
        tick(); #2;
        check("sync_n2_fab_Q", bus.fab_Q[0],    1'b1);
        check("sync_n2_edge",  bus.fab_edge[0], 1'b1);
        tick(); #2;
        check("sync_n3_edge",  bus.fab_edge[0], 1'b0);

        // Channel 1 OUT_REG+O_INV (0x0A), channel 0 T_REG (0x07)
        tick();
        bus.fab_I   = 2'b01;
        FrameData   = 32'h0000_0A07;
        FrameStrobe = 20'h00001;
        tick();
        FrameStrobe = '0;
        repeat (3) tick();
        bus.fab_I = 2'b11;
        bus.fab_T = 2'b01;
        #2;
        check("oreg_m_pad_I1", bus.pad_I[1], 1'b1);
        check("treg_m_pad_T0", bus.pad_T[0], 1'b0);
        tick();
        bus.fab_T = 2'b00;
        #2;
        check("oreg_m1_pad_I1", bus.pad_I[1], 1'b0);
        check("treg_m1_pad_T0", bus.pad_T[0], 1'b1);
        tick(); #2;
        check("treg_m2_pad_T0", bus.pad_T[0], 1'b0);

        // Reset in the middle of a load: nothing commits afterwards
        tick();
        FrameData   = 32'h0000_00FF;
        FrameStrobe = 20'h00001;
        RST = 1'b1;
        tick();
        tick();
        FrameStrobe = '0;
        tick();
        RST = 1'b0;
        bus.fab_T = 2'b10;
        #2;
        check("rstld_busy",  bus.cfg_busy, 1'b0);
        check("rstld_pad_T", bus.pad_T,    2'b10);
        tick();
        tick(); #2;
        check("rstld_cfg_C", bus.cfg_C,    8'h00);
        check("rstld_busy2", bus.cfg_busy, 1'b0);
        check("model_rst0",  m_active[0],  8'h00);

        // Randomized traffic, including unmapped frames, held strobes and resets
        for (int i = 0; i < 600; i++) begin
            tick();
            if (RST) begin
                RST = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                RST = 1'b1;
            end
            bus.pad_O = NCH'($urandom);
            bus.fab_I = NCH'($urandom);
            bus.fab_T = NCH'($urandom);
            if (hold > 0) begin
                hold--;
                FrameData = $urandom;
            end else if ($urandom_range(0, 5) == 0) begin
                FrameData = $urandom;
                case ($urandom_range(0, 3))
                    0, 1:    FrameStrobe = 20'h00001;
                    2:       FrameStrobe = 20'h00002;
                    default: FrameStrobe = MF'(20'h00001 << $urandom_range(0, MF-1));
                endcase
                hold = int'($urandom_range(0, 2));
            end else begin
                FrameStrobe = '0;
            end
        end

        tick();
        RST = 1'b0;
        FrameStrobe = '0;
        repeat (4) tick();
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
